// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - symbols and lane-phy state encoding shared by the tx striper/serializer and rx aligner
package phy_pkg;

    localparam logic [7:0] COMMA_BC        = 8'hBC;
    localparam int         ALIGN_COUNT_DEF = 4;
    localparam int         LANES_DEF       = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_e;

    // lane index width; a single lane still gets a 1-bit field
    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/serial_shift8.sv
// rtl/serial_shift8.sv - MSB-first serial-to-parallel window exposing the byte that includes the current bit
module serial_shift8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] nxt_o
);

    // only the last seven bits need storing; the eighth is the live input
    logic [6:0] sr_q;

    assign nxt_o = {sr_q, data_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= nxt_o[6:0];
        end
    end

endmodule

// File: rtl/serial_paralelo_rx_align.sv
// rtl/serial_paralelo_rx_align.sv - comma-aligned serial deserializer with round-robin lane tagging
module serial_paralelo_rx_align
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA       = COMMA_BC,
    parameter int         ALIGN_COUNT = ALIGN_COUNT_DEF,
    parameter int         LANES       = LANES_DEF,
    localparam int        LW          = lane_w(LANES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_in,
    output logic [7:0]    data_out,
    output logic          valid_out,
    output logic [LW-1:0] lane_id,
    output logic          byte_strobe,
    output logic          active
);

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    comma_cnt_q, comma_cnt_d;
    logic [LW-1:0] lane_ptr_q, lane_ptr_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          strobe_q, strobe_d;
    logic          active_q, active_d;

    logic [7:0]    nxt;
    logic          is_comma;
    logic          boundary;
    logic [LW-1:0] lane_ptr_inc;

    serial_shift8 u_shift (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .nxt_o   (nxt)
    );

    assign is_comma     = (nxt == COMMA);
    assign boundary     = (bit_cnt_q == 3'd7);
    assign lane_ptr_inc = (lane_ptr_q == LW'(LANES - 1)) ? '0 : lane_ptr_q + LW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            lane_ptr_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            lane_q      <= '0;
            strobe_q    <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            lane_ptr_q  <= lane_ptr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            lane_q      <= lane_d;
            strobe_q    <= strobe_d;
            active_q    <= active_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        lane_ptr_d  = lane_ptr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        lane_d      = lane_q;
        strobe_d    = 1'b0;
        active_d    = active_q;

        case (state_q)
            SEARCH: begin
                bit_cnt_d = '0;
                if (is_comma) begin
                    comma_cnt_d = 4'd1;
                    if (ALIGN_COUNT == 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                // only boundary-phase symbols count; anything else there breaks the run
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + 4'd1;
                        if (comma_cnt_q + 4'd1 == 4'(ALIGN_COUNT)) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_d   = nxt;
                    strobe_d = 1'b1;
                    if (is_comma) begin
                        valid_d    = 1'b0;
                        lane_d     = '0;
                        lane_ptr_d = '0;
                    end else begin
                        valid_d    = 1'b1;
                        lane_d     = lane_ptr_q;
                        lane_ptr_d = lane_ptr_inc;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign lane_id     = lane_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx_align.sv
// tb/tb_serial_paralelo_rx_align.sv - scoreboard bench for the comma-aligned serial receiver
module tb_serial_paralelo_rx_align;

    localparam int         AC    = 4;
    localparam int         LANES = 4;
    localparam int         LW    = 2;
    localparam logic [7:0] BC    = 8'hBC;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          data_in = 1'b0;
    logic [7:0]    data_out;
    logic          valid_out;
    logic [LW-1:0] lane_id;
    logic          byte_strobe;
    logic          active;

    always #5 clk = ~clk;

    serial_paralelo_rx_align #(
        .COMMA       (BC),
        .ALIGN_COUNT (AC),
        .LANES       (LANES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .lane_id     (lane_id),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    typedef struct {
        logic [7:0] data;
        logic       valid;
        int         lane;
        int         at;
    } exp_t;

    exp_t       sbq[$];
    bit         stim[$];
    int         checks = 0;
    int         failures = 0;
    int         cur_edge = -1;
    int         exp_lock = -1;
    bit         mon_en = 1'b0;
    logic [7:0] h_data = '0;
    logic       h_valid = 1'b0;
    int         h_lane = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, cur_edge, act, exp);
        end
    endtask

    task automatic add_bit(input bit b);
        stim.push_back(b);
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
    endtask

    // the 8-bit window that ends with stream bit k (earlier bits read as 0 after reset)
    function automatic logic [7:0] win(input int k);
        logic [7:0] w = '0;
        for (int i = k - 7; i <= k; i++) w = {w[6:0], (i >= 0) ? logic'(stim[i]) : 1'b0};
        return w;
    endfunction

    // Hunt for a comma, then require AC commas spaced exactly 8 bits apart; after lock
    // every 8th bit closes a byte, delivered on that bit's edge.
    task automatic model(input int n);
        int k = 0;
        int lock = -1;
        int lane = 0;
        sbq.delete();
        while (lock < 0 && k < n) begin
            if (win(k) != BC) begin
                k++;
            end else begin
                int run = 1;
                int p = k;
                while (run < AC && p + 8 < n && win(p + 8) == BC) begin
                    p += 8;
                    run++;
                end
                if (run == AC) lock = p;
                else if (p + 8 >= n) k = n;
                else k = p + 9;
            end
        end
        exp_lock = lock;
        if (lock >= 0) begin
            for (int e = lock + 8; e < n; e += 8) begin
                logic [7:0] b = win(e);
                if (b == BC) begin
                    sbq.push_back('{data: b, valid: 1'b0, lane: 0, at: e});
                    lane = 0;
                end else begin
                    sbq.push_back('{data: b, valid: 1'b1, lane: lane, at: e});
                    lane = (lane + 1) % LANES;
                end
            end
        end
    endtask

    task automatic run(input int n);
        model(n);
        cur_edge = -1;
        mon_en   = 1'b1;
        for (int k = 0; k < n; k++) begin
            data_in = stim[k];
            @(posedge clk);
            cur_edge = k;
            @(negedge clk);
        end
        #1;
        mon_en = 1'b0;
        chk("sb_drain", sbq.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_data", int'(data_out), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_lane", int'(lane_id), 0);
        chk("rst_strobe", int'(byte_strobe), 0);
        chk("rst_active", int'(active), 0);
    endtask

    // assert mid-cycle, outputs must clear without waiting for a clock edge
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        stim.delete();
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            h_data  = '0;
            h_valid = 1'b0;
            h_lane  = 0;
        end else if (cur_edge >= 0) begin
            bit   due;
            exp_t e;
            chk("active", int'(active), int'(exp_lock >= 0 && cur_edge >= exp_lock));
            due = (sbq.size() > 0) && (sbq[0].at == cur_edge);
            chk("byte_strobe", int'(byte_strobe), int'(due));
            if (due) begin
                e       = sbq.pop_front();
                h_data  = e.data;
                h_valid = e.valid;
                h_lane  = e.lane;
            end
            chk("data_out", int'(data_out), int'(h_data));
            chk("valid_out", int'(valid_out), int'(h_valid));
            chk("lane_id", int'(lane_id), h_lane);
        end
    end

    initial begin
        #1;
        chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // random prefix then four commas: lock, no strobe before active
        repeat (3) add_bit(1'($urandom_range(0, 1)));
        repeat (4) add_byte(BC);
        add_byte(8'h11);
        run(stim.size());
        do_reset();

        // back-to-back data, lane wraps 3 -> 0
        repeat (4) add_byte(BC);
        add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h44); add_byte(8'h55);
        run(stim.size());
        do_reset();

        // idle comma in the middle of data re-phases lanes
        repeat (4) add_byte(BC);
        add_byte(8'h11); add_byte(BC); add_byte(8'h22);
        run(stim.size());
        do_reset();

        // alignment broken by a data byte, then relock
        add_byte(BC); add_byte(BC); add_byte(8'hA5);
        repeat (4) add_byte(BC);
        add_byte(8'h7E);
        run(stim.size());
        do_reset();

        // lone comma at an odd offset followed by data never locks
        add_bit(1'b1); add_bit(1'b0); add_bit(1'b1);
        add_byte(BC);
        repeat (5) add_byte(8'h00);
        run(stim.size());
        do_reset();

        // reset mid-stream after lock, then a fresh alignment
        repeat (4) add_byte(BC);
        repeat (6) add_byte(8'($urandom_range(0, 255)));
        run(40 + 4 * 8 + int'($urandom_range(0, 20)));
        do_reset();
        repeat (2) add_bit(1'($urandom_range(0, 1)));
        repeat (4) add_byte(BC);
        add_byte(8'h3C); add_byte(8'hC3);
        run(stim.size());
        do_reset();

        // randomized streams with sprinkled idles and random commas
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 7)) add_bit(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) add_byte(BC);
            repeat (4) add_byte(BC);
            for (int j = 0; j < 30; j++) begin
                if ($urandom_range(0, 3) == 0) add_byte(BC);
                else add_byte(8'($urandom_range(0, 255)));
            end
            run(stim.size());
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx_align.md
Name: serial_paralelo_rx_align

Overview:
Receive-side counterpart of the lane transmitter/serializer path. Takes the 1-bit serial stream (MSB first) and finds byte boundaries by hunting for the 0xBC comma. Declares link active after a run of consecutive aligned commas, then delivers deserialized bytes. Idle commas are flagged invalid; data bytes are tagged with a round-robin lane index for the downstream un-striper. Runs entirely in the serial clock domain and emits a byte strobe in place of a derived slow clock.

Parameters:
COMMA, 8'hBC, idle/alignment symbol
ALIGN_COUNT, 4, consecutive aligned commas required to enter ACTIVE (range 1..15)
LANES, 4, lanes for lane_id rotation (power of 2, 1..8)

Ports:
clk  input  1  serial bit clock; all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
data_in  input  1  serial bit, MSB of each byte first
data_out  output  8  last deserialized byte; held between strobes
valid_out  output  1  1 = data_out is a non-comma byte received in ACTIVE; held with data_out
lane_id  output  $clog2(LANES) (min 1)  lane of current data_out
byte_strobe  output  1  one-cycle pulse on each byte boundary while ACTIVE
active  output  1  alignment achieved (recirculation/ready indication)

Behaviour:
- Reset (reset=0, async): shift register 0, bit_cnt 0, comma_cnt 0, state SEARCH. data_out=8'h00, valid_out=0, lane_id=0, byte_strobe=0, active=0. Deasserting reset mid-byte restarts in SEARCH; no partial byte is ever output.
- Every edge: sr <= {sr[6:0], data_in}; nxt = {sr[6:0], data_in}.
- SEARCH: bit-by-bit compare nxt==COMMA. On match: bit_cnt<=0, comma_cnt<=1, go ALIGN. With ALIGN_COUNT=1, go directly to ACTIVE: active=1 on the next edge, no strobe for this comma.
- ALIGN: bit_cnt increments 0..7, wrapping. When bit_cnt==7 (byte boundary) and nxt==COMMA: comma_cnt+1. If comma_cnt+1==ALIGN_COUNT, go ACTIVE and set active=1. When nxt!=COMMA at a boundary: comma_cnt<=0, back to SEARCH. Commas off the boundary are ignored in ALIGN.
- ACTIVE: at each boundary (bit_cnt==7):
  - data_out<=nxt; byte_strobe<=1 for exactly that cycle.
  - Comma byte: valid_out<=0, lane_id<=0 (commas re-phase lanes).
  - Other byte: valid_out<=1, lane_id<=lane_ptr, lane_ptr<=lane_ptr+1 mod LANES.
  - Latency: outputs update on the same edge that samples bit 0 (LSB) of the byte; visible 1 cycle later and held 8 cycles.
- ACTIVE is left only by reset. No loss-of-lock detection in this block.
- lane_ptr resets to 0 on reset and on each comma in ACTIVE.
- Boundary cases:
  - A comma that straddles the boundary by shifting bits while in ALIGN counts as a non-comma, so the block returns to SEARCH.
  - Back-to-back data with no commas: lane_id wraps LANES-1 -> 0.
- byte_strobe and active are registered, with no combinational path from data_in.

Decomposition:
- Shared package phy_pkg: COMMA_BC=8'hBC, default ALIGN_COUNT, LANES, and state encoding SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2. This package is shared with the tx-side striper/serializer.
- One natural sub-module: serial_shift8, an 8-bit MSB-first shift register with an nxt output.
- FSM, counters and lane rotation stay in the top level.

Test Plan:
- Reset mid-stream: drive reset=0 at an arbitrary bit -> all outputs 0 within the same timestep, state SEARCH; after release, the first strobe occurs only after re-alignment.
- Alignment: 3 random bits, then 4×0xBC MSB-first -> active rises 1 cycle after the last bit of the 4th comma; no byte_strobe beforehand.
- Data after lock: 0xBC×4, then 0x11, 0x22, 0x33, 0x44, 0x55 -> strobes every 8 cycles, data_out 0x11..0x55, valid_out=1, lane_id 0,1,2,3,0.
- Idle insertion: after lock send 0x11, 0xBC, 0x22 -> (0x11,v=1,lane 0), (0xBC,v=0,lane 0), (0x22,v=1,lane 0).
- Broken alignment: 0xBC, 0xBC, 0xA5, 0xBC×4, 0x7E -> ALIGN aborts at 0xA5 back to SEARCH; lock after the final 4 commas; 0x7E delivered with lane_id=0.
- False comma in SEARCH: bit pattern containing 0xBC at a non-byte offset followed by non-comma bytes -> active stays 0.
